mem_bus_demux: RTL and testbench

//  Routes one CPU data-memory request to one of three slaves (0=RAM default, 1=IO, 2=TIMER) by address decode,

---
 rtl/mem_bus_demux_pkg.sv | 34 +++
 rtl/mem_bus_addr_decode.sv | 28 ++
 rtl/mem_bus_demux.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_demux.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_demux_pkg.sv
// Shared definitions for the CPU data-port demultiplexer:
// FSM state encoding, slave indices, default decode windows and a one-hot helper.
package mem_bus_demux_pkg;

    localparam int unsigned NUM_SLV     = 3;
    localparam int unsigned TIMEOUT_DEF = 16;

    localparam logic [31:0] S1_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] S1_MASK_DEF = 32'hFFFF_FF00;
    localparam logic [31:0] S2_BASE_DEF = 32'h0000_7F20;
    localparam logic [31:0] S2_MASK_DEF = 32'hFFFF_FFF0;

    localparam logic [1:0] SLV_RAM = 2'd0;
    localparam logic [1:0] SLV_IO  = 2'd1;
    localparam logic [1:0] SLV_TMR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Slave index -> one-hot request vector; unknown index falls back to RAM.
    function automatic logic [NUM_SLV-1:0] slv_onehot(input logic [1:0] sel);
        logic [NUM_SLV-1:0] oh;
        case (sel)
            SLV_IO:  oh = 3'b010;
            SLV_TMR: oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Address decoder: maps a byte address to a slave index.
// Ports:
//   addr_i   in   ADDR_W  byte address
//   sel_c_o  out  2       slave index (combinational): IO window, else TIMER window, else RAM
module mem_bus_addr_decode
    import mem_bus_demux_pkg::*;
#(
    parameter int unsigned        ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  S1_BASE = ADDR_W'(S1_BASE_DEF),
    parameter logic [ADDR_W-1:0]  S1_MASK = ADDR_W'(S1_MASK_DEF),
    parameter logic [ADDR_W-1:0]  S2_BASE = ADDR_W'(S2_BASE_DEF),
    parameter logic [ADDR_W-1:0]  S2_MASK = ADDR_W'(S2_MASK_DEF)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [1:0]        sel_c_o
);

    // Slave 1 is tested first so it wins where the windows overlap.
    always_comb begin
        sel_c_o = SLV_RAM;
        if ((addr_i & S1_MASK) == S1_BASE) begin
            sel_c_o = SLV_IO;
        end else if ((addr_i & S2_MASK) == S2_BASE) begin
            sel_c_o = SLV_TMR;
        end
    end

endmodule

// File: rtl/mem_bus_demux.sv
// CPU data-memory demultiplexer: routes one request at a time to RAM / IO / TIMER
// by address decode and returns the selected slave's read data and ack.
// Ports:
//   Clk, Rst_N                 clock, synchronous active-low reset
//   M_Req/M_We/M_Addr/M_WData/M_Be   master request
//   M_Ready                    combinational, high in IDLE
//   M_Rsp_Valid/M_RData/M_Err  registered one-cycle response (data/err held)
//   S_Req/S_We/S_Addr/S_WData/S_Be   registered slave request
//   S_Ack, S_RData_0/1/2       per-slave ack and read data
module mem_bus_demux
    import mem_bus_demux_pkg::*;
#(
    parameter int unsigned        WIDTH   = 32,
    parameter int unsigned        ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  S1_BASE = ADDR_W'(S1_BASE_DEF),
    parameter logic [ADDR_W-1:0]  S1_MASK = ADDR_W'(S1_MASK_DEF),
    parameter logic [ADDR_W-1:0]  S2_BASE = ADDR_W'(S2_BASE_DEF),
    parameter logic [ADDR_W-1:0]  S2_MASK = ADDR_W'(S2_MASK_DEF),
    parameter int unsigned        TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst_N,
    input  logic                 M_Req,
    input  logic                 M_We,
    input  logic [ADDR_W-1:0]    M_Addr,
    input  logic [WIDTH-1:0]     M_WData,
    input  logic [WIDTH/8-1:0]   M_Be,
    output logic                 M_Ready,
    output logic                 M_Rsp_Valid,
    output logic [WIDTH-1:0]     M_RData,
    output logic                 M_Err,
    output logic [2:0]           S_Req,
    output logic                 S_We,
    output logic [ADDR_W-1:0]    S_Addr,
    output logic [WIDTH-1:0]     S_WData,
    output logic [WIDTH/8-1:0]   S_Be,
    input  logic [2:0]           S_Ack,
    input  logic [WIDTH-1:0]     S_RData_0,
    input  logic [WIDTH-1:0]     S_RData_1,
    input  logic [WIDTH-1:0]     S_RData_2
);

    localparam int unsigned BE_W  = WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    state_e              state_q, state_d;
    logic [2:0]          s_req_q, s_req_d;
    logic [1:0]          sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [1:0]          dec_sel;
    logic                ack_sel;
    logic [WIDTH-1:0]    rdata_sel;

    mem_bus_addr_decode #(
        .ADDR_W  (ADDR_W),
        .S1_BASE (S1_BASE),
        .S1_MASK (S1_MASK),
        .S2_BASE (S2_BASE),
        .S2_MASK (S2_MASK)
    ) u_decode (
        .addr_i  (M_Addr),
        .sel_c_o (dec_sel)
    );

    // Return path: only the latched slave's ack and data are looked at.
    always_comb begin
        ack_sel   = S_Ack[0];
        rdata_sel = S_RData_0;
        case (sel_q)
            SLV_IO: begin
                ack_sel   = S_Ack[1];
                rdata_sel = S_RData_1;
            end
            SLV_TMR: begin
                ack_sel   = S_Ack[2];
                rdata_sel = S_RData_2;
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        s_req_d     = s_req_q;
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = '0;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (M_Req) begin
                    we_d    = M_We;
                    addr_d  = M_Addr;
                    wdata_d = M_WData;
                    be_d    = M_Be;
                    sel_d   = dec_sel;
                    s_req_d = slv_onehot(dec_sel);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the final timeout cycle still completes normally.
                if (ack_sel) begin
                    rdata_d     = we_q ? '0 : rdata_sel;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    s_req_d     = '0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    s_req_d     = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                s_req_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            state_q     <= ST_IDLE;
            s_req_q     <= '0;
            sel_q       <= SLV_RAM;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_req_q     <= s_req_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign M_Ready     = (state_q == ST_IDLE);
    assign M_Rsp_Valid = rsp_valid_q;
    assign M_RData     = rdata_q;
    assign M_Err       = err_q;
    assign S_Req       = s_req_q;
    assign S_We        = we_q;
    assign S_Addr      = addr_q;
    assign S_WData     = wdata_q;
    assign S_Be        = be_q;

endmodule

// File: tb/tb_mem_bus_demux.sv
// Bench for mem_bus_demux: transaction-level reference model checked every cycle,
// plus directed transactions with literal expectations.
module tb_mem_bus_demux;

    localparam int unsigned TO  = 16;
    // With the default masks the TIMER window lies entirely inside the IO window,
    // so IO is narrowed to 0x7F00-0x7F1F here to make the TIMER slave reachable.
    localparam logic [31:0] S1B = 32'h0000_7F00;
    localparam logic [31:0] S1M = 32'hFFFF_FFE0;
    localparam logic [31:0] S2B = 32'h0000_7F20;
    localparam logic [31:0] S2M = 32'hFFFF_FFF0;

    logic        Clk = 1'b0;
    logic        Rst_N = 1'b0;
    logic        M_Req = 1'b0;
    logic        M_We = 1'b0;
    logic [31:0] M_Addr = '0;
    logic [31:0] M_WData = '0;
    logic [3:0]  M_Be = '0;
    logic        M_Ready, M_Rsp_Valid, M_Err;
    logic [31:0] M_RData;
    logic [2:0]  S_Req;
    logic        S_We;
    logic [31:0] S_Addr, S_WData;
    logic [3:0]  S_Be;
    logic [2:0]  S_Ack = '0;
    logic [31:0] S_RData_0 = '0;
    logic [31:0] S_RData_1 = '0;
    logic [31:0] S_RData_2 = '0;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    mem_bus_demux #(
        .WIDTH(32), .ADDR_W(32),
        .S1_BASE(S1B), .S1_MASK(S1M), .S2_BASE(S2B), .S2_MASK(S2M),
        .TIMEOUT(TO)
    ) u_dut (
        .Clk(Clk), .Rst_N(Rst_N),
        .M_Req(M_Req), .M_We(M_We), .M_Addr(M_Addr), .M_WData(M_WData), .M_Be(M_Be),
        .M_Ready(M_Ready), .M_Rsp_Valid(M_Rsp_Valid), .M_RData(M_RData), .M_Err(M_Err),
        .S_Req(S_Req), .S_We(S_We), .S_Addr(S_Addr), .S_WData(S_WData), .S_Be(S_Be),
        .S_Ack(S_Ack), .S_RData_0(S_RData_0), .S_RData_1(S_RData_1), .S_RData_2(S_RData_2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (one transaction in flight) ----------------
    logic        m_valid = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_rsp = 1'b0;
    int unsigned m_waited = 0;
    int unsigned m_sel = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_be = '0;
    logic        m_err = 1'b0;

    function automatic int unsigned decode(input logic [31:0] a);
        if ((a & S1M) == S1B) return 1;
        if ((a & S2M) == S2B) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] slave_data(input int unsigned s);
        if (s == 1) return S_RData_1;
        if (s == 2) return S_RData_2;
        return S_RData_0;
    endfunction

    initial forever begin
        @(posedge Clk);
        if (!Rst_N) begin
            m_valid = 1'b1; m_busy = 1'b0; m_rsp = 1'b0; m_waited = 0; m_sel = 0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0; m_err = 1'b0;
        end else if (m_valid) begin
            if (m_rsp) begin
                m_rsp = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_waited++;
                if (S_Ack[m_sel[1:0]]) begin
                    m_rdata = m_we ? 32'h0 : slave_data(m_sel);
                    m_err = 1'b0;
                    m_rsp = 1'b1;
                end else if (m_waited == TO) begin
                    m_rdata = 32'h0;
                    m_err = 1'b1;
                    m_rsp = 1'b1;
                end
            end else if (M_Req) begin
                m_busy = 1'b1; m_waited = 0; m_sel = decode(M_Addr);
                m_we = M_We; m_addr = M_Addr; m_wdata = M_WData; m_be = M_Be;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge Clk);
        if (m_valid) begin
            check("m_ready", 64'(M_Ready), 64'(!m_busy));
            check("s_req", 64'(S_Req), (m_busy && !m_rsp) ? 64'(3'b001 << m_sel) : 64'(0));
            check("rsp_valid", 64'(M_Rsp_Valid), 64'(m_rsp));
            check("rdata", 64'(M_RData), 64'(m_rdata));
            check("err", 64'(M_Err), 64'(m_err));
            check("s_we", 64'(S_We), 64'(m_we));
            check("s_addr", 64'(S_Addr), 64'(m_addr));
            check("s_wdata", 64'(S_WData), 64'(m_wdata));
            check("s_be", 64'(S_Be), 64'(m_be));
        end
    end

    // One transaction. Ack on slave ack_idx in WAIT cycle ack_dly+1 (ack_idx<0: none);
    // spur is OR'd into S_Ack in the first WAIT cycle; busy_req keeps a write request
    // pending while busy. lat = cycles from accept edge until M_Rsp_Valid is seen.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                           input logic [3:0] be, input int ack_idx, input int ack_dly,
                           input logic [2:0] spur, input logic busy_req, input logic [31:0] rd,
                           output int lat, output logic [2:0] sreq1,
                           output logic [31:0] rdata, output logic err);
        @(negedge Clk);
        M_Req = 1'b1; M_We = we; M_Addr = addr; M_WData = wd; M_Be = be;
        S_RData_0 = (ack_idx == 0) ? rd : ~rd;
        S_RData_1 = (ack_idx == 1) ? rd : ~rd;
        S_RData_2 = (ack_idx == 2) ? rd : ~rd;
        lat = 0; sreq1 = '0; rdata = '0; err = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (busy_req) begin
                M_Req = 1'b1; M_We = 1'b1; M_Addr = 32'h0000_7F04;
            end else begin
                M_Req = 1'b0;
            end
            if (c == 1) sreq1 = S_Req;
            if (M_Rsp_Valid) begin
                lat = c; rdata = M_RData; err = M_Err;
                break;
            end
            S_Ack = ((ack_idx >= 0 && c == ack_dly + 1) ? (3'b001 << ack_idx) : 3'b000)
                  | ((c == 1) ? spur : 3'b000);
        end
        M_Req = 1'b0;
        S_Ack = '0;
        check("rsp_seen", 64'(lat != 0), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [2:0]  sreq1;
        logic [31:0] rd;
        logic        er;
        int          rsp_cnt, rdy_cnt;

        repeat (2) @(negedge Clk);
        Rst_N = 1'b1;
        check("reset_ready", 64'(M_Ready), 64'(1));
        check("reset_sreq", 64'(S_Req), 64'(0));
        check("reset_rsp", 64'(M_Rsp_Valid), 64'(0));

        // 1: RAM read, immediate ack
        run_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 3'b000, 1'b0, 32'h1234_5678, lat, sreq1, rd, er);
        check("t1_sreq", 64'(sreq1), 64'(3'b001));
        check("t1_lat", 64'(lat), 64'(2));
        check("t1_rdata", 64'(rd), 64'(32'h1234_5678));
        check("t1_err", 64'(er), 64'(0));

        // 2: IO write
        run_txn(32'h0000_7F04, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 0, 3'b000, 1'b0, 32'hDEAD_0001, lat, sreq1, rd, er);
        check("t2_sreq", 64'(sreq1), 64'(3'b010));
        check("t2_wdata", 64'(S_WData), 64'(32'hA5A5_A5A5));
        check("t2_be", 64'(S_Be), 64'(4'b0011));
        check("t2_rdata", 64'(rd), 64'(0));
        check("t2_err", 64'(er), 64'(0));

        // 3: TIMER read, ack delayed 5 cycles, new request pending while busy
        run_txn(32'h0000_7F24, 1'b0, 32'h0, 4'hF, 2, 5, 3'b000, 1'b1, 32'h0F0F_1234, lat, sreq1, rd, er);
        check("t3_sreq", 64'(sreq1), 64'(3'b100));
        check("t3_lat", 64'(lat), 64'(7));
        check("t3_rdata", 64'(rd), 64'(32'h0F0F_1234));
        check("t3_addr_held", 64'(S_Addr), 64'(32'h0000_7F24));

        // 4: IO read with no ack -> timeout, then a normal transaction
        run_txn(32'h0000_7F00, 1'b0, 32'h0, 4'hF, -1, 0, 3'b000, 1'b0, 32'h5555_AAAA, lat, sreq1, rd, er);
        check("t4_sreq", 64'(sreq1), 64'(3'b010));
        check("t4_lat", 64'(lat), 64'(TO + 1));
        check("t4_err", 64'(er), 64'(1));
        check("t4_rdata", 64'(rd), 64'(0));
        run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 3'b000, 1'b0, 32'hCAFE_F00D, lat, sreq1, rd, er);
        check("t4b_lat", 64'(lat), 64'(2));
        check("t4b_err", 64'(er), 64'(0));
        check("t4b_rdata", 64'(rd), 64'(32'hCAFE_F00D));

        // 5: stray ack from IO while RAM is selected
        run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 0, 3, 3'b010, 1'b0, 32'h7777_0005, lat, sreq1, rd, er);
        check("t5_lat", 64'(lat), 64'(5));
        check("t5_rdata", 64'(rd), 64'(32'h7777_0005));

        // 6a: M_Req held high with RAM always acking -> one transaction every 3 cycles
        @(negedge Clk);
        M_Req = 1'b1; M_We = 1'b0; M_Addr = 32'h0000_0040; S_RData_0 = 32'h0BAD_BEEF; S_Ack = 3'b001;
        rsp_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            if (M_Rsp_Valid) rsp_cnt++;
            if (M_Ready) rdy_cnt++;
        end
        M_Req = 1'b0; S_Ack = '0;
        check("t6_rsp_cnt", 64'(rsp_cnt), 64'(3));
        check("t6_rdy_cnt", 64'(rdy_cnt), 64'(3));

        // 6b: reset during WAIT abandons the transaction
        @(negedge Clk);
        M_Req = 1'b1; M_Addr = 32'h0000_0300;
        @(negedge Clk);
        M_Req = 1'b0;
        check("t6_in_wait", 64'(S_Req), 64'(3'b001));
        @(negedge Clk);
        Rst_N = 1'b0;
        @(negedge Clk);
        Rst_N = 1'b1;
        check("t6_rst_sreq", 64'(S_Req), 64'(0));
        check("t6_rst_ready", 64'(M_Ready), 64'(1));
        rsp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (M_Rsp_Valid) rsp_cnt++;
        end
        check("t6_no_rsp", 64'(rsp_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
